// File: rtl/clk_div_switch.sv
// ============================================================================
// clk_div_switch : glitch-free N-channel clock divider with handshake-driven
// channel selection (drain high phase, forced low gap, clean restart).
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_switch #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 8,
   parameter int GAP_CYCLES = 2,
   parameter int RESET_CH   = 0,
   parameter int SEL_W      = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*CNT_W-1:0] div_ratio,
   input  logic                    sel_valid,
   input  logic [SEL_W-1:0]        sel_ch,
   output logic                    busy,
   output logic                    switch_done,
   output logic                    sel_err,
   output logic [SEL_W-1:0]        cur_ch,
   output logic                    clk_out
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   per_len;
   logic [CNT_W-1:0]   per_hi;
   logic [GAP_W-1:0]   gap_cnt;
   logic [SEL_W-1:0]   target;
   logic               start_pend;

   logic [CNT_W-1:0]   ratio_arr [0:2**SEL_W-1];

   genvar gi;
   generate
      for (gi = 0; gi < 2**SEL_W; gi++) begin : g_ratio
         if (gi < NUM_CH) begin : g_used
            assign ratio_arr[gi] = div_ratio[gi*CNT_W +: CNT_W];
         end else begin : g_unused
            assign ratio_arr[gi] = '0;
         end
      end
   endgenerate

   // Ratios below 2 cannot form a high and a low phase, so they run as 2.
   function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] r);
      return (r < CNT_W'(2)) ? CNT_W'(2) : r;
   endfunction

   logic [CNT_W-1:0] run_len;
   logic [CNT_W-1:0] tgt_len;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_next;
   logic             wrap;
   logic             period_start;
   logic             div_hi;
   logic             accept;
   logic             req_bad;
   logic             req_same;

   assign run_len      = eff_len(ratio_arr[cur_ch]);
   assign tgt_len      = eff_len(ratio_arr[target]);
   assign cnt_inc      = cnt + CNT_W'(1);
   assign wrap         = (cnt == per_len - CNT_W'(1));
   assign period_start = start_pend | wrap;
   assign div_hi       = period_start | (cnt_inc < per_hi);
   assign cnt_next     = period_start ? '0 : cnt_inc;

   assign accept   = sel_valid & ~busy & (state == ST_RUN);
   assign req_bad  = (32'(sel_ch) >= NUM_CH);
   assign req_same = (sel_ch == cur_ch);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         cnt         <= '0;
         per_len     <= CNT_W'(2);
         per_hi      <= CNT_W'(1);
         gap_cnt     <= '0;
         target      <= SEL_W'(RESET_CH);
         start_pend  <= 1'b1;
         busy        <= 1'b0;
         switch_done <= 1'b0;
         sel_err     <= 1'b0;
         cur_ch      <= SEL_W'(RESET_CH);
         clk_out     <= 1'b0;
      end else begin
         switch_done <= 1'b0;
         sel_err     <= 1'b0;
         case (state)
            ST_RUN: begin
               if (accept && !req_bad && !req_same) begin
                  target <= sel_ch;
                  busy   <= 1'b1;
                  // A high phase in progress must finish; a low phase is cut short.
                  if (clk_out && div_hi) begin
                     state   <= ST_DRAIN;
                     cnt     <= cnt_next;
                     clk_out <= 1'b1;
                  end else begin
                     state   <= ST_GAP;
                     gap_cnt <= GAP_W'(1);
                     clk_out <= 1'b0;
                  end
               end else begin
                  cnt     <= cnt_next;
                  clk_out <= div_hi;
                  if (period_start) begin
                     per_len    <= run_len;
                     per_hi     <= run_len >> 1;
                     start_pend <= 1'b0;
                  end
                  if (accept && req_bad) begin
                     sel_err <= 1'b1;
                  end
                  if (accept && !req_bad && req_same) begin
                     switch_done <= 1'b1;
                  end
               end
            end

            ST_DRAIN: begin
               if (div_hi) begin
                  cnt     <= cnt_next;
                  clk_out <= 1'b1;
               end else begin
                  state   <= ST_GAP;
                  gap_cnt <= GAP_W'(1);
                  clk_out <= 1'b0;
               end
            end

            ST_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
                  state       <= ST_RUN;
                  cur_ch      <= target;
                  cnt         <= '0;
                  per_len     <= tgt_len;
                  per_hi      <= tgt_len >> 1;
                  start_pend  <= 1'b0;
                  clk_out     <= 1'b1;
                  busy        <= 1'b0;
                  switch_done <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
                  clk_out <= 1'b0;
               end
            end

            default: begin
               state   <= ST_RUN;
               busy    <= 1'b0;
               clk_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
